// File: rtl/pht_update_queue_if.sv
// Branch-result in / PHT write-port out bundle for pht_update_queue.
// master drives resolved branches, slave is the queue.
interface pht_update_queue_if #(
  parameter int INDEX_BITS = 9,
  parameter int CTR_NUM    = 4,
  parameter int CTR_WIDTH  = 2,
  parameter int IN_NUM     = 2,
  parameter int DEPTH      = 8
);
  localparam int ENTRY_W = CTR_NUM * CTR_WIDTH;
  localparam int SEL_W   = $clog2(CTR_NUM);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [IN_NUM-1:0]            inValid;
  logic [IN_NUM*INDEX_BITS-1:0] inIndex;
  logic [IN_NUM*SEL_W-1:0]      inCtrSel;
  logic [IN_NUM*ENTRY_W-1:0]    inPrevEntry;
  logic [IN_NUM-1:0]            inTaken;
  logic                         inReady;
  logic                         phtWE;
  logic [INDEX_BITS-1:0]        phtWA;
  logic [ENTRY_W-1:0]           phtWV;
  logic                         initBusy;
  logic [CNT_W-1:0]             count;
  logic [15:0]                  dropCount;

  modport master (
    output inValid, inIndex, inCtrSel,
    output inPrevEntry, inTaken,
    input  inReady, phtWE, phtWA, phtWV,
    input  initBusy, count, dropCount
  );

  modport slave (
    input  inValid, inIndex, inCtrSel,
    input  inPrevEntry, inTaken,
    output inReady, phtWE, phtWA, phtWV,
    output initBusy, count, dropCount
  );
endinterface

// File: rtl/pht_update_queue.sv
// PHT write side: saturating counter updates, coalescing queue,
// single write port drain and post-reset init sweep.
module pht_update_queue #(
  parameter int INDEX_BITS = 9,
  parameter int CTR_NUM    = 4,
  parameter int CTR_WIDTH  = 2,
  parameter int IN_NUM     = 2,
  parameter int DEPTH      = 8
) (
  input logic              clk,
  input logic              rst,
  pht_update_queue_if.slave bus
);
  localparam int ENTRY_NUM = 1 << INDEX_BITS;
  localparam int ENTRY_W   = CTR_NUM * CTR_WIDTH;
  localparam int SEL_W     = $clog2(CTR_NUM);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CTR_WIDTH-1:0] MAX =
    {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] MID =
    {1'b1, {(CTR_WIDTH-1){1'b0}}};
  localparam logic [ENTRY_W-1:0] INIT_V = {CTR_NUM{MID}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state;
  logic [INDEX_BITS-1:0] init_idx;
  logic [INDEX_BITS-1:0] idx_q [DEPTH];
  logic [ENTRY_W-1:0]    val_q [DEPTH];
  logic [INDEX_BITS-1:0] idx_n [DEPTH];
  logic [ENTRY_W-1:0]    val_n [DEPTH];
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      cnt;
  logic [15:0]           drop;

  logic                  run, deq, in_ready, hit;
  int                    alloc, nv, p;
  logic [PTR_W-1:0]      slot, head_n, tail_n;
  logic [CNT_W-1:0]      cnt_n;
  logic [15:0]           drop_n;
  logic [16:0]           drop_sum;
  logic [INDEX_BITS-1:0] li;
  logic [SEL_W-1:0]      ls;
  logic [ENTRY_W-1:0]    base, upd;
  logic [CTR_WIDTH-1:0]  ctr, ctr_n;

  always_comb begin
    run      = rst && (state == S_RUN);
    deq      = run && (cnt != '0);
    in_ready = run &&
      ((CNT_W'(DEPTH) - cnt) >= CNT_W'(IN_NUM));
    idx_n    = idx_q;
    val_n    = val_q;
    alloc    = 0;
    nv       = 0;
    p        = 0;
    hit      = 1'b0;
    slot     = '0;
    li       = '0;
    ls       = '0;
    base     = '0;
    upd      = '0;
    ctr      = '0;
    ctr_n    = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      nv = nv + int'(bus.inValid[i]);
      if (in_ready && bus.inValid[i]) begin
        li   = bus.inIndex[i*INDEX_BITS +: INDEX_BITS];
        ls   = bus.inCtrSel[i*SEL_W +: SEL_W];
        base = bus.inPrevEntry[i*ENTRY_W +: ENTRY_W];
        hit  = 1'b0;
        slot = '0;
        // live slots include ones allocated by earlier lanes
        for (int k = 0; k < DEPTH; k++) begin
          p = (int'(head) + k) % DEPTH;
          if (k < int'(cnt) + alloc &&
              !(k == 0 && deq) &&
              idx_n[p] == li) begin
            hit  = 1'b1;
            slot = PTR_W'(p);
            base = val_n[p];
          end
        end
        if (!hit) begin
          slot = PTR_W'((int'(tail) + alloc) % DEPTH);
          if (deq && idx_q[head] == li)
            base = val_q[head];
          alloc = alloc + 1;
        end
        ctr = base[int'(ls)*CTR_WIDTH +: CTR_WIDTH];
        unique case (1'b1)
          bus.inTaken[i] && ctr != MAX:
            ctr_n = ctr + 1'b1;
          !bus.inTaken[i] && ctr != '0:
            ctr_n = ctr - 1'b1;
          default: ctr_n = ctr;
        endcase
        upd = base;
        upd[int'(ls)*CTR_WIDTH +: CTR_WIDTH] = ctr_n;
        idx_n[slot] = li;
        val_n[slot] = upd;
      end
    end
    cnt_n  = cnt + CNT_W'(alloc) - CNT_W'(deq);
    head_n = !deq ? head :
      (head == PTR_W'(DEPTH-1)) ? '0 : head + 1'b1;
    tail_n = PTR_W'((int'(tail) + alloc) % DEPTH);
    drop_sum = {1'b0, drop} + 17'(nv);
    drop_n   = drop;
    if (run && !in_ready)
      drop_n = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_INIT;
      init_idx <= '0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      drop     <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == INDEX_BITS'(ENTRY_NUM-1))
            state <= S_RUN;
        end
        default: begin
          idx_q <= idx_n;
          val_q <= val_n;
          head  <= head_n;
          tail  <= tail_n;
          cnt   <= cnt_n;
          drop  <= drop_n;
        end
      endcase
    end
  end

  assign bus.inReady   = in_ready;
  assign bus.initBusy  = !rst || (state == S_INIT);
  assign bus.phtWE     = rst &&
    (state == S_INIT || cnt != '0);
  assign bus.phtWA     = (state == S_INIT) ?
    init_idx : idx_q[head];
  assign bus.phtWV     = (state == S_INIT) ?
    INIT_V : val_q[head];
  assign bus.count     = cnt;
  assign bus.dropCount = drop;
endmodule

// File: tb/tb_pht_update_queue.sv
// Directed bench for pht_update_queue: expected PHT writes go into
// a scoreboard queue, a negedge monitor pops them on every phtWE.
module tb_pht_update_queue;
  localparam int IB = 9;
  localparam int SW = 2;
  localparam int EW = 8;

  typedef struct {
    logic [IB-1:0] wa;
    logic [EW-1:0] wv;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wr_t  exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pht_update_queue_if #(
    .INDEX_BITS(9), .CTR_NUM(4), .CTR_WIDTH(2),
    .IN_NUM(2), .DEPTH(8)
  ) bus ();

  pht_update_queue #(
    .INDEX_BITS(9), .CTR_NUM(4), .CTR_WIDTH(2),
    .IN_NUM(2), .DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int wa, input int wv);
    wr_t w;
    w.wa = IB'(wa);
    w.wv = EW'(wv);
    exp_q.push_back(w);
  endtask

  task automatic push_init();
    for (int i = 0; i < 512; i++) push(i, 8'hAA);
  endtask

  task automatic clear_in();
    bus.inValid     = '0;
    bus.inIndex     = '0;
    bus.inCtrSel    = '0;
    bus.inPrevEntry = '0;
    bus.inTaken     = '0;
  endtask

  task automatic lane(input int i, input int idx,
                      input int sel, input int prev,
                      input logic tk);
    bus.inValid[i]           = 1'b1;
    bus.inIndex[i*IB +: IB]  = IB'(idx);
    bus.inCtrSel[i*SW +: SW] = SW'(sel);
    bus.inPrevEntry[i*EW +: EW] = EW'(prev);
    bus.inTaken[i]           = tk;
  endtask

  // called at posedge+1 with lanes set; returns at next posedge+1
  task automatic issue(input logic rdy);
    @(negedge clk);
    chk("inReady", 32'(bus.inReady), 32'(rdy));
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_init();
    int t;
    t = 0;
    while (bus.initBusy && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("init_done", 32'(bus.initBusy), 32'd0);
    chk("ready_after_init", 32'(bus.inReady), 32'd1);
    chk("init_writes_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (bus.phtWE === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: WA=%0d WV=%0h want none",
                 bus.phtWA, bus.phtWV);
      end else begin
        w = exp_q.pop_front();
        chk("phtWA", 32'(bus.phtWA), 32'(w.wa));
        chk("phtWV", 32'(bus.phtWV), 32'(w.wv));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rdy_pat;
    int t;
    clear_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(bus.phtWE), 32'd0);
    chk("rst_busy", 32'(bus.initBusy), 32'd1);
    chk("rst_ready", 32'(bus.inReady), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_drop", 32'(bus.dropCount), 32'd0);
    push_init();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_init();

    push(5, 8'h0C);
    lane(0, 5, 1, 8'h08, 1'b1);
    issue(1'b1);
    chk("t2_count1", 32'(bus.count), 32'd1);
    idle(1);
    chk("t2_count0", 32'(bus.count), 32'd0);

    push(7, 8'h02);
    lane(0, 7, 0, 8'h00, 1'b1);
    lane(1, 7, 0, 8'h00, 1'b1);
    issue(1'b1);
    chk("t3_count1", 32'(bus.count), 32'd1);
    idle(1);
    chk("t3_count0", 32'(bus.count), 32'd0);

    push(9, 8'h03);
    lane(0, 9, 0, 8'h03, 1'b1);
    issue(1'b1);
    push(10, 8'h00);
    lane(0, 10, 0, 8'h00, 1'b0);
    issue(1'b1);
    push(11, 8'hC0);
    lane(1, 11, 3, 8'hC0, 1'b1);
    issue(1'b1);
    idle(2);
    chk("t4_count0", 32'(bus.count), 32'd0);

    // merge into a queued slot and re-allocate behind the dequeuing head
    push(20, 8'h01);
    push(21, 8'h05);
    push(20, 8'h00);
    lane(0, 20, 0, 8'h00, 1'b1);
    lane(1, 21, 0, 8'h00, 1'b1);
    issue(1'b1);
    lane(0, 21, 1, 8'hFF, 1'b1);
    lane(1, 20, 0, 8'hFF, 1'b0);
    issue(1'b1);
    chk("merge_count", 32'(bus.count), 32'd2);
    idle(3);
    chk("merge_drain", 32'(bus.count), 32'd0);

    rdy_pat = 8'b1011_1111;
    for (int k = 0; k < 8; k++) begin
      lane(0, 200 + 2*k, 0, 8'h00, 1'b1);
      lane(1, 201 + 2*k, 0, 8'h00, 1'b1);
      if (rdy_pat[k]) begin
        push(200 + 2*k, 8'h01);
        push(201 + 2*k, 8'h01);
      end
      issue(rdy_pat[k]);
    end
    chk("t5_count7", 32'(bus.count), 32'd7);
    chk("t5_drop", 32'(bus.dropCount), 32'd2);
    t = 0;
    while (bus.count != 0 && t < 20) begin
      idle(1);
      t++;
    end
    chk("t5_drained", 32'(bus.count), 32'd0);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    push(100, 8'h01);
    push(101, 8'h01);
    push(102, 8'h01);
    for (int k = 0; k < 4; k++) begin
      lane(0, 100 + 2*k, 0, 8'h00, 1'b1);
      lane(1, 101 + 2*k, 0, 8'h00, 1'b1);
      issue(1'b1);
    end
    chk("t6_count5", 32'(bus.count), 32'd5);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_count0", 32'(bus.count), 32'd0);
    chk("t6_we", 32'(bus.phtWE), 32'd0);
    chk("t6_busy", 32'(bus.initBusy), 32'd1);
    chk("t6_drop", 32'(bus.dropCount), 32'd0);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    push_init();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_init();
    idle(2);
    chk("t6_final_count", 32'(bus.count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
